// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one two-port SRAM between two read and two write clients.
// Read data returns one cycle after grant, tagged with the owning client.

`ifndef INTERNAL_BITS
`define INTERNAL_BITS 16
`endif

module sram_port_arbiter #(
    parameter int ADDR_BITS    = 13,
    parameter int DATA_BITS    = `INTERNAL_BITS,
    parameter int HAZARD_STALL = 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 r0_req,
    input  logic [ADDR_BITS-1:0] r0_addr,
    output logic                 r0_gnt,
    input  logic                 r1_req,
    input  logic [ADDR_BITS-1:0] r1_addr,
    output logic                 r1_gnt,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 r0_rvalid,
    output logic                 r1_rvalid,
    input  logic                 w0_req,
    input  logic [ADDR_BITS-1:0] w0_addr,
    input  logic [DATA_BITS-1:0] w0_data,
    output logic                 w0_gnt,
    input  logic                 w1_req,
    input  logic [ADDR_BITS-1:0] w1_addr,
    input  logic [DATA_BITS-1:0] w1_data,
    output logic                 w1_gnt,
    output logic                 sram_cena,
    output logic [ADDR_BITS-1:0] sram_aa,
    input  logic [DATA_BITS-1:0] sram_qa,
    output logic                 sram_cenb,
    output logic                 sram_wenb,
    output logic [ADDR_BITS-1:0] sram_ab,
    output logic [DATA_BITS-1:0] sram_db
);

    localparam bit STALL_EN = (HAZARD_STALL != 0);

    logic       wptr;
    logic       rptr;
    logic [1:0] rtag;
    logic       wr_any;
    logic       hit0;
    logic       hit1;

    always_comb begin
        w0_gnt = 1'b0;
        w1_gnt = 1'b0;
        if (RSTN) begin
            if (w0_req && w1_req) begin
                w0_gnt = ~wptr;
                w1_gnt = wptr;
            end else begin
                w0_gnt = w0_req;
                w1_gnt = w1_req;
            end
        end
        wr_any    = w0_gnt | w1_gnt;
        sram_cenb = wr_any;
        sram_wenb = wr_any;
        sram_ab   = '0;
        sram_db   = '0;
        if (w0_gnt) begin
            sram_ab = w0_addr;
            sram_db = w0_data;
        end else if (w1_gnt) begin
            sram_ab = w1_addr;
            sram_db = w1_data;
        end
    end

    // A read colliding with this cycle's write address is skipped; the other reader may take the slot.
    always_comb begin
        hit0   = STALL_EN && wr_any && (r0_addr == sram_ab);
        hit1   = STALL_EN && wr_any && (r1_addr == sram_ab);
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (RSTN) begin
            if (r0_req && r1_req) begin
                if (!rptr) begin
                    if (!hit0)      r0_gnt = 1'b1;
                    else if (!hit1) r1_gnt = 1'b1;
                end else begin
                    if (!hit1)      r1_gnt = 1'b1;
                    else if (!hit0) r0_gnt = 1'b1;
                end
            end else begin
                r0_gnt = r0_req && !hit0;
                r1_gnt = r1_req && !hit1;
            end
        end
        sram_cena = r0_gnt | r1_gnt;
        sram_aa   = '0;
        if (r0_gnt)      sram_aa = r0_addr;
        else if (r1_gnt) sram_aa = r1_addr;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            rtag <= 2'b00;
        end else begin
            if (w0_gnt)      wptr <= 1'b1;
            else if (w1_gnt) wptr <= 1'b0;
            if (r0_gnt)      rptr <= 1'b1;
            else if (r1_gnt) rptr <= 1'b0;
            rtag <= {r1_gnt, r0_gnt};
        end
    end

    assign r0_rvalid = rtag[0];
    assign r1_rvalid = rtag[1];
    assign rdata     = sram_qa;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one stalling and one non-stalling instance,
// each with its own behavioural read-before-write SRAM.

module tb_sram_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          r0_req = 1'b0, r1_req = 1'b0, w0_req = 1'b0, w1_req = 1'b0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0, w0_addr = '0, w1_addr = '0;
    logic [DW-1:0] w0_data = '0, w1_data = '0;

    logic          h_r0_gnt, h_r1_gnt, h_r0_rvalid, h_r1_rvalid, h_w0_gnt, h_w1_gnt;
    logic          h_cena, h_cenb, h_wenb;
    logic [AW-1:0] h_aa, h_ab;
    logic [DW-1:0] h_rdata, h_db, h_qa;
    logic          n_r0_gnt, n_r1_gnt, n_r0_rvalid, n_r1_rvalid, n_w0_gnt, n_w1_gnt;
    logic          n_cena, n_cenb, n_wenb;
    logic [AW-1:0] n_aa, n_ab;
    logic [DW-1:0] n_rdata, n_db, n_qa;

    logic [DW-1:0] h_mem [0:(1<<AW)-1];
    logic [DW-1:0] n_mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    sram_port_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .HAZARD_STALL(1)) dut_h (
        .CLK(CLK), .RSTN(RSTN),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(h_r0_gnt),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(h_r1_gnt),
        .rdata(h_rdata), .r0_rvalid(h_r0_rvalid), .r1_rvalid(h_r1_rvalid),
        .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data), .w0_gnt(h_w0_gnt),
        .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data), .w1_gnt(h_w1_gnt),
        .sram_cena(h_cena), .sram_aa(h_aa), .sram_qa(h_qa),
        .sram_cenb(h_cenb), .sram_wenb(h_wenb), .sram_ab(h_ab), .sram_db(h_db)
    );

    sram_port_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .HAZARD_STALL(0)) dut_n (
        .CLK(CLK), .RSTN(RSTN),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(n_r0_gnt),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(n_r1_gnt),
        .rdata(n_rdata), .r0_rvalid(n_r0_rvalid), .r1_rvalid(n_r1_rvalid),
        .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data), .w0_gnt(n_w0_gnt),
        .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data), .w1_gnt(n_w1_gnt),
        .sram_cena(n_cena), .sram_aa(n_aa), .sram_qa(n_qa),
        .sram_cenb(n_cenb), .sram_wenb(n_wenb), .sram_ab(n_ab), .sram_db(n_db)
    );

    // Read-before-write SRAM models: a same-edge read returns the old contents.
    always @(posedge CLK) begin
        if (h_cenb && h_wenb) h_mem[h_ab] <= h_db;
        if (h_cena) h_qa <= h_mem[h_aa];
        if (n_cenb && n_wenb) n_mem[n_ab] <= n_db;
        if (n_cena) n_qa <= n_mem[n_aa];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic a_r0_req, input logic [AW-1:0] a_r0_addr,
                                 input logic a_r1_req, input logic [AW-1:0] a_r1_addr,
                                 input logic a_w0_req, input logic [AW-1:0] a_w0_addr, input logic [DW-1:0] a_w0_data,
                                 input logic a_w1_req, input logic [AW-1:0] a_w1_addr, input logic [DW-1:0] a_w1_data);
        r0_req = a_r0_req; r0_addr = a_r0_addr;
        r1_req = a_r1_req; r1_addr = a_r1_addr;
        w0_req = a_w0_req; w0_addr = a_w0_addr; w0_data = a_w0_data;
        w1_req = a_w1_req; w1_addr = a_w1_addr; w1_data = a_w1_data;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulseReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RSTN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        nextCycle();
    endtask

    initial begin
        // Reset: requests present but everything forced off
        applyStimulus(1, 'h010, 1, 'h011, 1, 'h010, 'h77, 1, 'h012, 'h66);
        checkOutput("rst_r0_gnt", h_r0_gnt, 0);
        checkOutput("rst_w0_gnt", h_w0_gnt, 0);
        checkOutput("rst_w1_gnt", h_w1_gnt, 0);
        checkOutput("rst_cena", h_cena, 0);
        checkOutput("rst_cenb", h_cenb, 0);
        checkOutput("rst_wenb", h_wenb, 0);
        checkOutput("rst_ab", h_ab, 0);
        checkOutput("rst_rvalid", {h_r1_rvalid, h_r0_rvalid}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        nextCycle();
        checkOutput("idle_en", {h_cena, h_cenb, h_wenb, h_r0_gnt, h_r1_gnt, h_w0_gnt, h_w1_gnt}, 0);

        // 1: write 0x010=0xA5 then read it back through R0
        applyStimulus(0, 0, 0, 0, 1, 'h010, 'h00A5, 0, 0, 0);
        checkOutput("t1_w0_gnt", h_w0_gnt, 1);
        checkOutput("t1_cenb_wenb", {h_cenb, h_wenb}, 2'b11);
        checkOutput("t1_ab", h_ab, 'h010);
        checkOutput("t1_db", h_db, 'h00A5);
        nextCycle();
        applyStimulus(1, 'h010, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_r0_gnt", h_r0_gnt, 1);
        checkOutput("t1_cena", h_cena, 1);
        checkOutput("t1_aa", h_aa, 'h010);
        checkOutput("t1_cenb_idle", h_cenb, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_r0_rvalid", h_r0_rvalid, 1);
        checkOutput("t1_r1_rvalid", h_r1_rvalid, 0);
        checkOutput("t1_rdata", h_rdata, 'h00A5);
        nextCycle();
        checkOutput("t1_rvalid_drop", {h_r1_rvalid, h_r0_rvalid}, 0);

        // 2: both writers continuously, pointers fresh from reset
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 'h001, DW'('h100 + i), 1, 'h002, DW'('h200 + i));
            checkOutput($sformatf("t2_w0_gnt_%0d", i), h_w0_gnt, (i % 2 == 0));
            checkOutput($sformatf("t2_w1_gnt_%0d", i), h_w1_gnt, (i % 2 == 1));
            checkOutput($sformatf("t2_ab_%0d", i), h_ab, (i % 2 == 0) ? 'h001 : 'h002);
            checkOutput($sformatf("t2_db_%0d", i), h_db, (i % 2 == 0) ? 'h100 + i : 'h200 + i);
            nextCycle();
        end

        // 3: both readers continuously; mem[1]=0x102, mem[2]=0x203
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 'h001, 1, 'h002, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("t3_r0_gnt_%0d", i), h_r0_gnt, (i % 2 == 0));
            checkOutput($sformatf("t3_r1_gnt_%0d", i), h_r1_gnt, (i % 2 == 1));
            checkOutput($sformatf("t3_aa_%0d", i), h_aa, (i % 2 == 0) ? 'h001 : 'h002);
            if (i > 0) begin
                checkOutput($sformatf("t3_tag_%0d", i), {h_r1_rvalid, h_r0_rvalid}, (i % 2 == 1) ? 2'b01 : 2'b10);
                checkOutput($sformatf("t3_rdata_%0d", i), h_rdata, (i % 2 == 1) ? 'h102 : 'h203);
            end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_tag_last", {h_r1_rvalid, h_r0_rvalid}, 2'b10);
        checkOutput("t3_rdata_last", h_rdata, 'h203);
        nextCycle();
        checkOutput("t3_tag_idle", {h_r1_rvalid, h_r0_rvalid}, 0);

        // 4/5: read of the address being written, stalling vs non-stalling instance
        applyStimulus(0, 0, 0, 0, 1, 'h020, 'h0011, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 'h020, 0, 0, 1, 'h020, 'h0022, 0, 0, 0);
        checkOutput("t4_w0_gnt", h_w0_gnt, 1);
        checkOutput("t4_r0_stall", h_r0_gnt, 0);
        checkOutput("t4_cena_stall", h_cena, 0);
        checkOutput("t5_r0_gnt", n_r0_gnt, 1);
        nextCycle();
        applyStimulus(1, 'h020, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_r0_gnt_retry", h_r0_gnt, 1);
        checkOutput("t4_no_rvalid", h_r0_rvalid, 0);
        checkOutput("t5_r0_rvalid", n_r0_rvalid, 1);
        checkOutput("t5_rdata_old", n_rdata, 'h0011);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_r0_rvalid", h_r0_rvalid, 1);
        checkOutput("t4_rdata_new", h_rdata, 'h0022);
        nextCycle();

        // Hazard on the priority reader hands the slot to the other reader
        pulseReset();
        applyStimulus(1, 'h030, 1, 'h002, 1, 'h030, 'h0033, 0, 0, 0);
        checkOutput("t4b_r0_gnt", h_r0_gnt, 0);
        checkOutput("t4b_r1_gnt", h_r1_gnt, 1);
        checkOutput("t4b_aa", h_aa, 'h002);
        checkOutput("t4b_n_r0_gnt", n_r0_gnt, 1);
        nextCycle();
        applyStimulus(1, 'h030, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4b_r0_gnt_next", h_r0_gnt, 1);
        checkOutput("t4b_r1_rvalid", h_r1_rvalid, 1);
        checkOutput("t4b_rdata", h_rdata, 'h203);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4b_rdata_new", h_rdata, 'h0033);
        nextCycle();

        // 6: reset lands between an R1 grant and its data cycle
        applyStimulus(1, 'h010, 0, 0, 1, 'h040, 'h0055, 0, 0, 0);
        checkOutput("t6_r0_gnt", h_r0_gnt, 1);
        checkOutput("t6_w0_gnt", h_w0_gnt, 1);
        nextCycle();
        applyStimulus(0, 0, 1, 'h002, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_r1_gnt", h_r1_gnt, 1);
        checkOutput("t6_r0_rvalid", h_r0_rvalid, 1);
        RSTN = 1'b0;
        #1;
        checkOutput("t6_rst_r1_gnt", h_r1_gnt, 0);
        checkOutput("t6_rst_en", {h_cena, h_cenb, h_wenb}, 0);
        checkOutput("t6_rst_rvalid", {h_r1_rvalid, h_r0_rvalid}, 0);
        nextCycle();
        checkOutput("t6_r1_rvalid_dropped", h_r1_rvalid, 0);
        @(negedge CLK);
        RSTN = 1'b1;
        applyStimulus(1, 'h010, 1, 'h002, 1, 'h050, 'h0001, 1, 'h051, 'h0002);
        checkOutput("t6_wptr_reset", {h_w1_gnt, h_w0_gnt}, 2'b01);
        checkOutput("t6_rptr_reset", {h_r1_gnt, h_r0_gnt}, 2'b01);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_r0_rvalid_after", h_r0_rvalid, 1);
        checkOutput("t6_rdata_after", h_rdata, 'h00A5);
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one TwoPort_SRAM instance between two read clients (R0, R1) and two write clients (W0, W1).
- Drives the SRAM read port (A) and write port (B) from the same clock.
- Arbitrates each port independently with round-robin and returns read data with a client tag.
- Optionally stalls a read that targets the address being written in the same cycle.
- Sits between the conv PE array / feature-map loader and the on-chip buffer.

Parameters:
- ADDR_BITS, 13, SRAM address width; must match the SRAM instance.
- DATA_BITS, `INTERNAL_BITS, data width; must match the SRAM instance.
- HAZARD_STALL, 1, 1 = block a read whose address equals the granted write address that cycle; 0 = allow it, and the read returns the old data.

Ports:
- CLK in 1: single clock. Also drives the SRAM's CLKA and CLKB externally.
- RSTN in 1: asynchronous active-low reset.
- r0_req in 1: read request, client 0.
- r0_addr in ADDR_BITS: read address, client 0.
- r0_gnt out 1: read accepted this cycle, client 0.
- r1_req in 1: read request, client 1.
- r1_addr in ADDR_BITS: read address, client 1.
- r1_gnt out 1: read accepted this cycle, client 1.
- rdata out DATA_BITS: read data, shared by both read clients (equals QA).
- r0_rvalid out 1: rdata belongs to client 0.
- r1_rvalid out 1: rdata belongs to client 1.
- w0_req in 1: write request, client 0.
- w0_addr in ADDR_BITS: write address, client 0.
- w0_data in DATA_BITS: write data, client 0.
- w0_gnt out 1: write accepted this cycle, client 0.
- w1_req in 1: write request, client 1.
- w1_addr in ADDR_BITS: write address, client 1.
- w1_data in DATA_BITS: write data, client 1.
- w1_gnt out 1: write accepted this cycle, client 1.
- sram_cena out 1: to SRAM CENA (active-high read enable).
- sram_aa out ADDR_BITS: to SRAM AA.
- sram_qa in DATA_BITS: from SRAM QA.
- sram_cenb out 1: to SRAM CENB (active-high).
- sram_wenb out 1: to SRAM WENB (active-high).
- sram_ab out ADDR_BITS: to SRAM AB.
- sram_db out DATA_BITS: to SRAM DB.

Behaviour:
- Handshake:
  - A request is accepted in the cycle where req=1 and gnt=1.
  - Clients hold req, addr and data stable until granted.
  - gnt is combinational from the req inputs, the priority pointers and the hazard check.
  - At most one read grant and one write grant per cycle.
- Write arbitration:
  - Single pointer wptr; reset value 0, meaning W0 has priority.
  - Only one requester: it is granted.
  - Both request: the client named by wptr is granted.
  - After any write grant, wptr becomes the index of the non-granted client.
  - sram_cenb = sram_wenb = (w0_gnt | w1_gnt); sram_ab and sram_db are muxed from the granted client.
  - The write completes at that clock edge.
- Read arbitration:
  - Same round-robin scheme with pointer rptr; reset value 0.
  - sram_cena = (r0_gnt | r1_gnt); sram_aa comes from the granted client.
- Hazard (HAZARD_STALL=1):
  - Applies when a write grant exists and the read candidate's address equals sram_ab.
  - That candidate is not granted this cycle.
  - If the other read client requests a different address, it is granted instead; rptr updates as a normal grant.
  - Otherwise no read is granted and rptr is unchanged.
  - Writes are never stalled.
- Read latency:
  - A grant in cycle N sets a registered tag.
  - In cycle N+1: rN_rvalid=1 for exactly one cycle, and rdata = sram_qa holds the data.
  - Back-to-back grants give back-to-back rvalid with no bubble.
  - Zero grants give rvalid=0 the next cycle.
- Registered state: wptr, rptr, rvalid tag (2 bits). All other outputs are combinational.
- Reset (RSTN=0, asynchronous):
  - wptr=0, rptr=0, r0_rvalid=r1_rvalid=0.
  - While in reset, all gnt outputs, sram_cena, sram_cenb and sram_wenb are forced 0.
  - sram_aa, sram_ab and sram_db are 0 when not granted.
- Reset asserted mid-read: the pending rvalid is dropped, and the client must re-request.
- Undefined-free: with no requests, all enables and grants are 0 and the pointers hold.

Test Plan:
1. Reset, then W0 writes addr 0x010 = 0xA5, then R0 reads 0x010 -> r0_gnt in the same cycle; next cycle r0_rvalid=1, rdata=0xA5, r1_rvalid=0.
2. W0 and W1 request continuously for 4 cycles (addrs 0x001 / 0x002) -> grants alternate W0, W1, W0, W1; sram_ab alternates 0x001, 0x002, 0x001, 0x002.
3. R0 and R1 request continuously for 4 cycles -> grants alternate R0, R1, R0, R1; rvalid tags follow one cycle later with no bubble.
4. HAZARD_STALL=1, mem[0x020]=0x11; same cycle W0 writes 0x020=0x22 and R0 reads 0x020 -> r0_gnt=0 that cycle; next cycle r0_gnt=1; following cycle rdata=0x22.
5. HAZARD_STALL=0, same stimulus as 4 -> r0_gnt=1 immediately; next cycle rdata=0x11 (old data).
6. R1 granted, RSTN pulsed low before the next edge -> r1_rvalid stays 0, all enables 0 during reset, both pointers return to 0.
